// File: rtl/game_over_ctrl.sv
// Game-over arbiter: filters N_CH request lines, latches the first confirmed
// winner or a timeout draw, and re-arms through a restart/quiet handshake.
module game_over_ctrl #(
  parameter int N_CH           = 2,
  parameter int CONFIRM_CYCLES = 4,
  parameter int TIMEOUT_CYCLES = 0,
  parameter int WIN_W          = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_CH-1:0]  gameover,
  input  logic             restart,
  output logic             over,
  output logic             winner_valid,
  output logic [WIN_W-1:0] winner,
  output logic             draw,
  output logic             ready
);

  localparam int CW = $clog2(CONFIRM_CYCLES + 1);
  localparam int TW = (TIMEOUT_CYCLES > 0) ?
                      $clog2(TIMEOUT_CYCLES + 1) : 1;

  localparam logic [CW-1:0] CNT_MAX = CW'(CONFIRM_CYCLES);
  localparam logic [CW-1:0] CNT_HIT = CW'(CONFIRM_CYCLES - 1);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMO_HIT = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_RUN,
    S_OVER,
    S_CLEAR
  } state_t;

  state_t                  state_q, state_d;
  logic [N_CH-1:0][CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0]           tmo_q, tmo_d;
  logic                    over_q, over_d;
  logic                    wv_q, wv_d;
  logic [WIN_W-1:0]        win_q, win_d;
  logic                    draw_q, draw_d;
  logic                    ready_q, ready_d;

  logic [N_CH-1:0]         hit_now;
  logic                    hit;
  logic [WIN_W-1:0]        hit_idx;

  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      hit_now[i] = gameover[i] && (cnt_q[i] == CNT_HIT);
    end
    hit     = 1'b0;
    hit_idx = '0;
    // Descending scan so the lowest confirming index is the one kept
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (hit_now[i]) begin
        hit     = 1'b1;
        hit_idx = WIN_W'(i);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    over_d  = over_q;
    wv_d    = wv_q;
    win_d   = win_q;
    draw_d  = draw_q;
    ready_d = ready_q;
    unique case (state_q)
      S_RUN: begin
        for (int i = 0; i < N_CH; i++) begin
          if (!gameover[i])
            cnt_d[i] = '0;
          else if (cnt_q[i] != CNT_MAX)
            cnt_d[i] = cnt_q[i] + CW'(1);
        end
        if (TIMEOUT_CYCLES > 0 && tmo_q != TMO_MAX)
          tmo_d = tmo_q + TW'(1);
        if (hit) begin
          state_d = S_OVER;
          cnt_d   = '0;
          tmo_d   = '0;
          over_d  = 1'b1;
          wv_d    = 1'b1;
          win_d   = hit_idx;
          draw_d  = 1'b0;
          ready_d = 1'b0;
        end else if (TIMEOUT_CYCLES > 0 && tmo_q == TMO_HIT) begin
          state_d = S_OVER;
          cnt_d   = '0;
          tmo_d   = '0;
          over_d  = 1'b1;
          wv_d    = 1'b0;
          win_d   = '0;
          draw_d  = 1'b1;
          ready_d = 1'b0;
        end
      end
      S_OVER: begin
        cnt_d = '0;
        tmo_d = '0;
        if (restart) begin
          state_d = S_CLEAR;
          over_d  = 1'b0;
          wv_d    = 1'b0;
          win_d   = '0;
          draw_d  = 1'b0;
          ready_d = 1'b0;
        end
      end
      S_CLEAR: begin
        cnt_d = '0;
        tmo_d = '0;
        // A stale request must fully drop before the next round arms
        if (gameover == '0) begin
          state_d = S_RUN;
          ready_d = 1'b1;
        end
      end
      default: begin
        state_d = S_RUN;
        cnt_d   = '0;
        tmo_d   = '0;
        over_d  = 1'b0;
        wv_d    = 1'b0;
        win_d   = '0;
        draw_d  = 1'b0;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_RUN;
      cnt_q   <= '0;
      tmo_q   <= '0;
      over_q  <= 1'b0;
      wv_q    <= 1'b0;
      win_q   <= '0;
      draw_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      over_q  <= over_d;
      wv_q    <= wv_d;
      win_q   <= win_d;
      draw_q  <= draw_d;
      ready_q <= ready_d;
    end
  end

  assign over         = over_q;
  assign winner_valid = wv_q;
  assign winner       = win_q;
  assign draw         = draw_q;
  assign ready        = ready_q;

endmodule

// File: doc/game_over_ctrl.md
Name: game_over_ctrl

Overview:
- Parametrised successor to the 2-bit game-over latch.
- Monitors N_CH game-over request lines from player/collision/UART logic.
- Filters each line against glitches, latches the first confirmed channel as the winner, and optionally ends the round as a draw on timeout.
- Provides a restart handshake that re-arms only after all request lines have gone quiet. Sits between game-logic and draw/UART-tx blocks.

Parameters:
- N_CH, 2, number of game-over request channels (>=1).
- CONFIRM_CYCLES, 4, consecutive high samples required to confirm a request (>=1; 1 = plain registered latch).
- TIMEOUT_CYCLES, 0, RUN-state cycles before a forced draw; 0 disables the timeout.
- WIN_W, derived = max(1, $clog2(N_CH)), width of the winner index.

Ports:
- clk  in  1  system clock (40 MHz).
- rst  in  1  asynchronous, active-low reset (asserted at 0).
- gameover  in  N_CH  per-channel game-over request, level.
- restart  in  1  restart request, sampled in OVER state only.
- over  out  1  round finished (winner or draw).
- winner_valid  out  1  over caused by a confirmed channel.
- winner  out  WIN_W  index of the winning channel; 0 when !winner_valid.
- draw  out  1  over caused by timeout.
- ready  out  1  block armed (RUN state).

Behaviour:
- Reset (rst=0, async): state=RUN, over=0, winner_valid=0, winner=0, draw=0, ready=1, all confirm counters and the timeout counter = 0. Deassertion is synchronous to the design via the normal clock.
- FSM states:
  - RUN: detect requests.
  - OVER: hold result.
  - CLEAR: wait for quiet inputs.
- RUN, per-channel counters:
  - Per channel i: cnt[i] increments (saturating at CONFIRM_CYCLES) on each edge where gameover[i]=1.
  - cnt[i] clears to 0 on any edge where gameover[i]=0.
- RUN, confirm:
  - Channel i is confirmed on the edge where it has been sampled high for CONFIRM_CYCLES consecutive edges.
  - On that edge: state->OVER, over=1, winner_valid=1, winner=i, ready=0.
  - Latency: request high before edge k -> outputs valid after edge k+CONFIRM_CYCLES-1.
- Simultaneous confirms on one edge: lowest index wins.
- RUN, timeout (TIMEOUT_CYCLES>0):
  - tmo counter increments every RUN edge.
  - On the edge it reaches TIMEOUT_CYCLES: state->OVER, over=1, draw=1, winner_valid=0, winner=0.
  - If a confirm and the timeout coincide on one edge, the confirm wins and draw=0.
- restart while in RUN: ignored.
- OVER:
  - All outputs hold.
  - Further gameover activity is ignored; counters are held at 0.
  - restart=1 sampled on an edge -> state->CLEAR.
- CLEAR:
  - over=0, winner_valid=0, winner=0, draw=0, ready=0.
  - Counters held at 0.
  - On the first edge where gameover == 0 (all channels low): state->RUN, ready=1, tmo=0.
  - A request line stuck high keeps the block in CLEAR indefinitely (no retrigger from a stale request).
- restart held high across OVER->CLEAR->RUN has no effect outside OVER.
- Glitch rejection: a pulse shorter than CONFIRM_CYCLES edges never sets over; a drop to 0 mid-count restarts that channel's count from 0.
- Reset mid-operation, from any state: immediately returns to reset values; the next round starts fresh.
- Width rules:
  - cnt width = $clog2(CONFIRM_CYCLES+1).
  - tmo width = $clog2(TIMEOUT_CYCLES+1) (1 bit when disabled).
  - No wrap: both counters saturate.
- Outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
- Reset, N_CH=2, CONFIRM_CYCLES=4: rst=0 for 30 ns then 1 -> over=0, winner_valid=0, winner=0, draw=0, ready=1. Apply rst=0 while in OVER -> outputs return to those values asynchronously.
- Confirm latency: gameover=2'b10 held -> over=1, winner=1, winner_valid=1 after the 4th sampling edge; over stays 1 after gameover returns to 2'b00.
- Glitch rejection: gameover=2'b01 for 3 edges, then 2'b00, then 2'b01 for 3 edges -> over stays 0. A 4th consecutive high edge -> over=1, winner=0.
- Tie and draw:
  - Tie: gameover=2'b11 asserted on the same edge -> winner=0.
  - Draw: with TIMEOUT_CYCLES=20 and no requests -> over=1, draw=1, winner_valid=0 on the 20th RUN edge.
  - Coincidence: a request confirming exactly on edge 20 -> draw=0, winner_valid=1.
- Restart handshake:
  - restart pulse in RUN -> no change.
  - In OVER, restart=1 with gameover=2'b10 still high -> over=0, ready=0 (CLEAR); block stays in CLEAR until gameover=2'b00, then ready=1 on the next edge.
  - A new 4-edge request then produces a fresh over=1.
- Parameter sweep: N_CH=5, CONFIRM_CYCLES=1 -> gameover=5'b10100 for one edge -> over=1, winner=3'd2 after that edge.
